// File: rtl/lut_sweep_pkg.sv
// ---------------------------------------------------------------------------
// lut_sweep_pkg
// Shared definitions for the LUT sweep controller:
//   - state_e        : controller FSM states
//   - *_DEF          : default widths for the controller parameters
//   - LEN_W          : sample-count width
//   - GAIN_SHIFT     : Q1.15 gain scaling shift (optional gain path only)
//   - saturate()     : clamp a signed value into a w-bit signed range
// ---------------------------------------------------------------------------
package lut_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int unsigned ADDR_W_DEF = 10;
  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned FRAC_W_DEF = 6;
  localparam int unsigned LEN_W      = 16;
  localparam int unsigned GAIN_SHIFT = 15;

  // Clamp x into [-(2^(w-1)), 2^(w-1)-1]; result is returned sign-extended
  // so callers take the low w bits.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] x,
                                                  input int unsigned        w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi) begin
      return hi;
    end else if (x < lo) begin
      return lo;
    end else begin
      return x;
    end
  endfunction

endpackage

// File: rtl/lut_sweep_ctrl_if.sv
// ---------------------------------------------------------------------------
// lut_sweep_ctrl_if
// Output sample stream of the LUT sweep controller (valid/ready handshake).
//   o_data  : sample, DATA_W bits, driven by the controller
//   o_valid : sample present, driven by the controller
//   i_ready : sink can accept, driven by the consumer
// A transfer happens on a rising clock edge where o_valid && i_ready.
// Modports: master (controller side), slave (consumer side).
// ---------------------------------------------------------------------------
interface lut_sweep_ctrl_if
  import lut_sweep_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) ();

  logic [DATA_W-1:0] o_data;
  logic              o_valid;
  logic              i_ready;

  modport master (
    output o_data,
    output o_valid,
    input  i_ready
  );

  modport slave (
    input  o_data,
    input  o_valid,
    output i_ready
  );

endinterface

// File: rtl/lut_sweep_acc.sv
// ---------------------------------------------------------------------------
// lut_sweep_acc
// Phase accumulator for the LUT sweep. Wraps modulo 2^W.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst   : synchronous active-high reset, clears the accumulator
//   i_load  : clear the accumulator to zero (start of a sweep)
//   i_en    : add i_step to the accumulator
//   i_step  : phase increment (integer.fraction)
//   o_acc   : current accumulator value
// i_load has priority over i_en.
// ---------------------------------------------------------------------------
module lut_sweep_acc #(
  parameter int unsigned W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic         i_en,
  input  logic [W-1:0] i_step,
  output logic [W-1:0] o_acc
);

  logic [W-1:0] acc_q;
  logic [W-1:0] acc_d;

  always_comb begin
    acc_d = acc_q;
    if (i_load) begin
      acc_d = '0;
    end else if (i_en) begin
      // Natural W-bit overflow gives the modulo wrap.
      acc_d = acc_q + i_step;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign o_acc = acc_q;

endmodule

// File: rtl/lut_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// lut_sweep_ctrl
// Sweeps a combinational lookup table with a fractional phase accumulator
// and streams the samples out over a valid/ready handshake.
//
// Ports:
//   i_clk       : clock, rising edge
//   i_rst       : synchronous active-high reset
//   i_start     : start pulse, honoured only in IDLE and only without i_stop
//   i_stop      : stop request, ends RUN early
//   i_step      : phase increment (ADDR_W.FRAC_W), latched at start
//   i_len       : sample count, 0 = run until stop, latched at start
//   o_lut_addr  : LUT address = integer part of the phase accumulator
//   i_lut_data  : LUT read data for o_lut_addr, same cycle
//   i_gain      : Q1.15 gain latched at start (LUT_SWEEP_GAIN_EN builds only)
//   o_busy      : high whenever the FSM is not in IDLE
//   o_done      : one-cycle pulse once the last sample has been handed off
//   out_if      : sample stream (o_data / o_valid / i_ready), master side
//
// Optional feature: define LUT_SWEEP_GAIN_EN to add i_gain and scale every
// sample by (data*gain)>>>15 with saturation; latency is unchanged.
// ---------------------------------------------------------------------------
module lut_sweep_ctrl
  import lut_sweep_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned FRAC_W = FRAC_W_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic                     i_stop,
  input  logic [ADDR_W+FRAC_W-1:0] i_step,
  input  logic [LEN_W-1:0]         i_len,
  output logic [ADDR_W-1:0]        o_lut_addr,
  input  logic [DATA_W-1:0]        i_lut_data,
`ifdef LUT_SWEEP_GAIN_EN
  input  logic [DATA_W-1:0]        i_gain,
`endif
  output logic                     o_busy,
  output logic                     o_done,
  lut_sweep_ctrl_if.master         out_if
);

  localparam int unsigned PH_W = ADDR_W + FRAC_W;

  state_e            state_q, state_d;
  logic [PH_W-1:0]   step_q, step_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  count_q, count_d;
  logic [LEN_W-1:0]  count_inc;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;

  logic [PH_W-1:0]   acc;
  logic              acc_load;
  logic              acc_en;
  logic              xfer;
  logic              slot_free;
  logic [DATA_W-1:0] sample;
  logic              unused_frac;

  // -------------------------------------------------------------------------
  // Phase accumulator
  // -------------------------------------------------------------------------
  lut_sweep_acc #(
    .W (PH_W)
  ) u_acc (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (acc_load),
    .i_en   (acc_en),
    .i_step (step_q),
    .o_acc  (acc)
  );

  assign o_lut_addr  = acc[PH_W-1:FRAC_W];
  assign unused_frac = ^acc[FRAC_W-1:0];

  // -------------------------------------------------------------------------
  // Sample path (optional gain)
  // -------------------------------------------------------------------------
`ifdef LUT_SWEEP_GAIN_EN
  logic signed [DATA_W-1:0]   gain_q, gain_d;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [63:0]         scaled;
  logic signed [63:0]         clipped;
  logic                       unused_clip;

  assign prod        = $signed(i_lut_data) * gain_q;
  assign scaled      = 64'(prod >>> GAIN_SHIFT);
  assign clipped     = saturate(scaled, DATA_W);
  assign sample      = clipped[DATA_W-1:0];
  assign unused_clip = ^clipped[63:DATA_W];

  always_comb begin
    gain_d = gain_q;
    if (state_q == ST_IDLE && i_start && !i_stop) begin
      gain_d = $signed(i_gain);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      gain_q <= '0;
    end else begin
      gain_q <= gain_d;
    end
  end
`else
  assign sample = i_lut_data;
`endif

  // -------------------------------------------------------------------------
  // Handshake helpers
  // -------------------------------------------------------------------------
  assign xfer      = valid_q && out_if.i_ready;
  assign slot_free = !valid_q || out_if.i_ready;
  assign count_inc = count_q + LEN_W'(1);

  // -------------------------------------------------------------------------
  // FSM next-state and datapath control
  // -------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    len_d    = len_q;
    count_d  = count_q;
    data_d   = data_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    acc_load = 1'b0;
    acc_en   = 1'b0;

    // A consumed sample frees the output register; a capture below in the
    // same cycle re-arms it.
    if (xfer) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (i_start && !i_stop) begin
          state_d  = ST_RUN;
          step_d   = i_step;
          len_d    = i_len;
          count_d  = '0;
          acc_load = 1'b1;
        end
      end

      ST_RUN: begin
        if (slot_free) begin
          data_d  = sample;
          valid_d = 1'b1;
          acc_en  = 1'b1;
          count_d = count_inc;
        end
        // The capture made in the stop cycle (or the final counted one) is
        // still delivered from DRAIN.
        if (i_stop || (slot_free && (len_q != '0) && (count_inc == len_q))) begin
          state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        if (!valid_q || xfer) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      len_q   <= '0;
      count_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      len_q   <= len_d;
      count_q <= count_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign out_if.o_data  = data_q;
  assign out_if.o_valid = valid_q;
  assign o_busy         = (state_q != ST_IDLE);
  assign o_done         = done_q;

endmodule

// File: doc/lut_sweep_ctrl.md
LUT_SWEEP_CTRL -- requirements
Module: lut_sweep_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, LUT address width (1024 entries).
REQ-002 SHALL have parameter DATA_W, default 16, LUT sample width, signed two's complement.
REQ-003 SHALL have parameter FRAC_W, default 6, fractional bits of the phase step.
REQ-004 SHALL have port i_clk, input, 1, the single clock; all logic rising-edge.
REQ-005 SHALL have port i_rst, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have port i_start, input, 1, start pulse; sampled only in IDLE.
REQ-007 SHALL have port i_stop, input, 1, stop request; ends RUN early.
REQ-008 SHALL have port i_step, input, ADDR_W+FRAC_W, unsigned phase increment (integer.fraction), sampled at start.
REQ-009 SHALL have port i_len, input, 16, number of samples; 0 = continuous until stop; sampled at start.
REQ-010 SHALL have port o_lut_addr, output, ADDR_W, address driven to the combinational LUT.
REQ-011 SHALL have port i_lut_data, input, DATA_W, LUT read data, valid in the same cycle as o_lut_addr.
REQ-012 SHALL have port o_data, output, DATA_W, registered output sample.
REQ-013 SHALL have ports o_valid (output, 1) and i_ready (input, 1), the output handshake; transfer when both are high.
REQ-014 SHALL have ports o_busy (output, 1, high outside IDLE) and o_done (output, 1, one-cycle completion pulse).

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DRAIN.
REQ-016 IDLE→RUN SHALL occur on i_start && !i_stop; it latches step/len and clears the accumulator and count.
REQ-017 o_lut_addr SHALL equal the integer field acc[ADDR_W+FRAC_W-1:FRAC_W] at all times.
REQ-018 In RUN, with slot free (!o_valid || i_ready), the block SHALL capture i_lut_data into o_data, set o_valid, add step to acc, and increment count.
REQ-019 First o_valid SHALL be asserted 2 cycles after the i_start cycle, given i_ready held high.
REQ-020 o_data and o_valid SHALL hold stable while o_valid && !i_ready; acc and count SHALL not advance.
REQ-021 acc SHALL wrap modulo 2^(ADDR_W+FRAC_W), so addresses wrap 1023→0 with no gap.
REQ-022 step = 0 SHALL repeatedly issue address 0.
REQ-023 When count reaches a nonzero len, RUN→DRAIN SHALL occur; no further samples are issued.
REQ-024 i_stop in RUN SHALL go to DRAIN the next cycle; a capture in the same cycle as i_stop SHALL still complete.
REQ-025 In DRAIN, the block SHALL wait until !o_valid or a transfer occurs, then pulse o_done for one cycle and return to IDLE.
REQ-026 i_start outside IDLE SHALL be ignored; i_start && i_stop in IDLE SHALL stay in IDLE.
REQ-027 len = 1 SHALL emit exactly one sample followed by o_done.

Reset
REQ-028 When i_rst is high at a clock edge: state = IDLE; acc, count, o_data = 0; o_valid, o_busy, o_done = 0. o_lut_addr SHALL read 0 in the cycle after reset.
REQ-029 Reset mid-RUN or mid-DRAIN SHALL abort without an o_done pulse; any pending sample is discarded.

Configuration
REQ-030 Macro LUT_SWEEP_GAIN_EN, when defined, SHALL add input i_gain (DATA_W, signed Q1.15, sampled at start).
REQ-031 With LUT_SWEEP_GAIN_EN defined, o_data SHALL be (i_lut_data*gain)>>>15, saturated to the DATA_W signed range; latency unchanged.
REQ-032 Without LUT_SWEEP_GAIN_EN, there SHALL be no i_gain port and o_data = i_lut_data unmodified.

Structure
REQ-033 Package lut_sweep_pkg SHALL hold the state enum typedef, default widths, and the saturate function.
REQ-034 The phase accumulator SHALL be sub-module lut_sweep_acc (load, enable, step in; acc out); the FSM and handshake remain in lut_sweep_ctrl.

Verification
REQ-035 step=0x40 (1.0), len=4, ready=1, LUT[n]=n: expect o_data 0,1,2,3, then o_done 1 cycle after the last transfer.
REQ-036 step=0x20 (0.5), len=6: expect addresses 0,0,1,1,2,2.
REQ-037 step=0x40, len=0, acc start near 1022: expect addresses 1022,1023,0,1 continuing until i_stop, then o_done.
REQ-038 ready toggled 1010… during len=8: expect o_data stable while stalled, exactly 8 transfers, no duplicates or drops.
REQ-039 i_rst asserted mid-RUN: expect o_valid=0, o_busy=0 next cycle, no o_done; a new i_start restarts at address 0.
REQ-040 LUT_SWEEP_GAIN_EN defined, gain=0x4000, LUT=0x7FFE: expect 0x3FFF; gain=0x8000, LUT=0x8000: expect saturation to 0x7FFF.
